// File: rtl/frame_bank_scheduler_pkg.sv
// Shared types and defaults for the double-buffered frame bank scheduler.
package frame_bank_scheduler_pkg;

    localparam int unsigned IMAGE_ROWS_DEFAULT = 160;
    localparam int unsigned CNT_WIDTH_DEFAULT  = 16;
    localparam int unsigned NUM_BANKS          = 2;

    // Ownership state of one frame bank
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } bank_state_e;

    // Producer handshake FSM
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_GRANT = 2'd1,
        W_WRITE = 2'd2
    } prod_state_e;

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Producer handshake plus video AXI-Stream snoop seen by the scheduler.
interface frame_bank_scheduler_if;

    logic prod_req_i;
    logic prod_grant_o;
    logic prod_bank_o;
    logic prod_done_i;
    logic vid_tvalid_i;
    logic vid_tready_i;
    logic vid_tlast_i;
    logic vid_tuser_i;

    // Scheduler side
    modport slave (
        input  prod_req_i,
        input  prod_done_i,
        input  vid_tvalid_i,
        input  vid_tready_i,
        input  vid_tlast_i,
        input  vid_tuser_i,
        output prod_grant_o,
        output prod_bank_o
    );

    // Producer / video side
    modport master (
        output prod_req_i,
        output prod_done_i,
        output vid_tvalid_i,
        output vid_tready_i,
        output vid_tlast_i,
        output vid_tuser_i,
        input  prod_grant_o,
        input  prod_bank_o
    );

endinterface

// File: rtl/frame_bank_scheduler_axis_frame_tracker.sv
// Tracks rows of the snooped video stream; flags frame end and start-of-frame resync.
module axis_frame_tracker #(
    parameter int unsigned IMAGE_ROWS = 160
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vid_tvalid_i,
    input  logic vid_tready_i,
    input  logic vid_tlast_i,
    input  logic vid_tuser_i,
    output logic frame_end_c_o,
    output logic sync_err_c_o
);

    localparam int unsigned ROW_W = (IMAGE_ROWS > 1) ? $clog2(IMAGE_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_ROWS - 1);

    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic             beat;

    assign beat = vid_tvalid_i & vid_tready_i;

    // Row advance on tlast beats; a tuser beat mid-frame resyncs without a frame end
    always_comb begin
        row_d         = row_q;
        frame_end_c_o = 1'b0;
        sync_err_c_o  = 1'b0;
        if (beat) begin
            if (vid_tuser_i && (row_q != '0)) begin
                sync_err_c_o = 1'b1;
                row_d        = '0;
            end else if (vid_tlast_i) begin
                if (row_q == LAST_ROW) begin
                    frame_end_c_o = 1'b1;
                    row_d         = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
        end
    end

    // Row counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Two-bank frame buffer scheduler: producer grants, display swaps at frame end, statistics.
module frame_bank_scheduler
    import frame_bank_scheduler_pkg::*;
#(
    parameter int unsigned IMAGE_ROWS = IMAGE_ROWS_DEFAULT,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    frame_bank_scheduler_if.slave sched_if,
    output logic                 rd_bank_o,
    output logic [CNT_WIDTH-1:0] frames_shown_o,
    output logic [CNT_WIDTH-1:0] frames_repeated_o,
    output logic [CNT_WIDTH-1:0] frames_dropped_o,
    output logic                 sync_err_o,
    output logic                 proto_err_o
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    bank_state_e          bank_q [NUM_BANKS];
    bank_state_e          bank_d [NUM_BANKS];
    prod_state_e          state_q, state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 prod_bank_q, prod_bank_d;
    logic                 grant_q, grant_d;
    logic [CNT_WIDTH-1:0] shown_q, shown_d;
    logic [CNT_WIDTH-1:0] repeated_q, repeated_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
    logic                 sync_err_q, sync_err_d;
    logic                 proto_err_q, proto_err_d;
    logic                 claim;
    logic                 frame_end_c;
    logic                 sync_err_c;

    axis_frame_tracker #(
        .IMAGE_ROWS (IMAGE_ROWS)
    ) u_tracker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .vid_tvalid_i  (sched_if.vid_tvalid_i),
        .vid_tready_i  (sched_if.vid_tready_i),
        .vid_tlast_i   (sched_if.vid_tlast_i),
        .vid_tuser_i   (sched_if.vid_tuser_i),
        .frame_end_c_o (frame_end_c),
        .sync_err_c_o  (sync_err_c)
    );

    // Frame-end swap decision from pre-edge bank states, then producer FSM
    always_comb begin
        bank_d      = bank_q;
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        prod_bank_d = prod_bank_q;
        grant_d     = 1'b0;
        shown_d     = shown_q;
        repeated_d  = repeated_q;
        dropped_d   = dropped_q;
        sync_err_d  = sync_err_q | sync_err_c;
        proto_err_d = proto_err_q;

        if (frame_end_c) begin
            if (bank_q[~rd_bank_q] == READY) begin
                bank_d[~rd_bank_q] = READING;
                bank_d[rd_bank_q]  = FREE;
                rd_bank_d          = ~rd_bank_q;
                shown_d            = sat_inc(shown_q);
            end else begin
                repeated_d = sat_inc(repeated_q);
            end
        end

        // Claim whichever bank is not being read after this edge's swap
        claim = ~rd_bank_d;

        case (state_q)
            W_IDLE: begin
                if (sched_if.prod_req_i) begin
                    if (bank_d[claim] == READY) begin
                        dropped_d = sat_inc(dropped_q);
                    end
                    bank_d[claim] = WRITING;
                    prod_bank_d   = claim;
                    grant_d       = 1'b1;
                    state_d       = W_GRANT;
                end
            end
            W_GRANT: begin
                state_d = W_WRITE;
            end
            W_WRITE: begin
                if (sched_if.prod_done_i) begin
                    bank_d[prod_bank_q] = READY;
                    state_d             = W_IDLE;
                end
            end
            default: begin
                state_d = W_IDLE;
            end
        endcase

        if (sched_if.prod_done_i && (state_q != W_WRITE)) begin
            proto_err_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q[0]   <= READING;
            bank_q[1]   <= FREE;
            state_q     <= W_IDLE;
            rd_bank_q   <= 1'b0;
            prod_bank_q <= 1'b1;
            grant_q     <= 1'b0;
            shown_q     <= '0;
            repeated_q  <= '0;
            dropped_q   <= '0;
            sync_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            prod_bank_q <= prod_bank_d;
            grant_q     <= grant_d;
            shown_q     <= shown_d;
            repeated_q  <= repeated_d;
            dropped_q   <= dropped_d;
            sync_err_q  <= sync_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign sched_if.prod_grant_o = grant_q;
    assign sched_if.prod_bank_o  = prod_bank_q;
    assign rd_bank_o             = rd_bank_q;
    assign frames_shown_o        = shown_q;
    assign frames_repeated_o     = repeated_q;
    assign frames_dropped_o      = dropped_q;
    assign sync_err_o            = sync_err_q;
    assign proto_err_o           = proto_err_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed vector bench for frame_bank_scheduler with 4-row frames and 3-bit counters.
module tb_frame_bank_scheduler;

    localparam int unsigned ROWS = 4;
    localparam int unsigned CW   = 3;

    typedef struct packed {
        logic          grant;
        logic          pbank;
        logic          rbank;
        logic [CW-1:0] shown;
        logic [CW-1:0] rep;
        logic [CW-1:0] drop;
        logic          serr;
        logic          perr;
    } obs_t;

    // vid code: 0 idle, 1 tlast beat, 2 stalled tlast (tready low), 3 tuser beat
    typedef struct packed {
        logic       req;
        logic       done;
        logic [1:0] vid;
        obs_t       e;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          rd_bank_o;
    logic [CW-1:0] frames_shown_o;
    logic [CW-1:0] frames_repeated_o;
    logic [CW-1:0] frames_dropped_o;
    logic          sync_err_o;
    logic          proto_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    frame_bank_scheduler_if sched_if ();

    frame_bank_scheduler #(
        .IMAGE_ROWS (ROWS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .sched_if          (sched_if),
        .rd_bank_o         (rd_bank_o),
        .frames_shown_o    (frames_shown_o),
        .frames_repeated_o (frames_repeated_o),
        .frames_dropped_o  (frames_dropped_o),
        .sync_err_o        (sync_err_o),
        .proto_err_o       (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic obs_t ex(input int g, input int pb, input int rb, input int sh,
                                input int rp, input int dr, input int se, input int pe);
        obs_t o;
        o.grant = 1'(g);
        o.pbank = 1'(pb);
        o.rbank = 1'(rb);
        o.shown = CW'(sh);
        o.rep   = CW'(rp);
        o.drop  = CW'(dr);
        o.serr  = 1'(se);
        o.perr  = 1'(pe);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("grant=%0d pbank=%0d rbank=%0d shown=%0d rep=%0d drop=%0d serr=%0d perr=%0d",
                         o.grant, o.pbank, o.rbank, o.shown, o.rep, o.drop, o.serr, o.perr);
    endfunction

    function automatic void add(input int req, input int done, input int vid, input obs_t e);
        vec_t v;
        v.req  = 1'(req);
        v.done = 1'(done);
        v.vid  = 2'(vid);
        v.e    = e;
        vecs.push_back(v);
    endfunction

    task automatic step(input int req, input int done, input int vid);
        sched_if.prod_req_i   = 1'(req);
        sched_if.prod_done_i  = 1'(done);
        sched_if.vid_tvalid_i = (vid != 0);
        sched_if.vid_tready_i = (vid == 1) || (vid == 3);
        sched_if.vid_tlast_i  = (vid == 1) || (vid == 2);
        sched_if.vid_tuser_i  = (vid == 3);
        @(posedge clk_i);
        #1;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a.grant = sched_if.prod_grant_o;
        a.pbank = sched_if.prod_bank_o;
        a.rbank = rd_bank_o;
        a.shown = frames_shown_o;
        a.rep   = frames_repeated_o;
        a.drop  = frames_dropped_o;
        a.serr  = sync_err_o;
        a.perr  = proto_err_o;
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got [%s] expected [%s]", name, fmt(a), fmt(e));
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        sched_if.prod_req_i   = 1'b0;
        sched_if.prod_done_i  = 1'b0;
        sched_if.vid_tvalid_i = 1'b0;
        sched_if.vid_tready_i = 1'b0;
        sched_if.vid_tlast_i  = 1'b0;
        sched_if.vid_tuser_i  = 1'b0;

        // Idle frame, grant/done/swap, then two producer frames inside one displayed frame
        for (int i = 0; i < 3; i++) add(0, 0, 1, ex(0, 1, 0, 0, 0, 0, 0, 0));
        add(0, 0, 1, ex(0, 1, 0, 0, 1, 0, 0, 0));
        add(1, 0, 0, ex(1, 1, 0, 0, 1, 0, 0, 0));
        add(1, 0, 0, ex(0, 1, 0, 0, 1, 0, 0, 0));
        add(1, 0, 0, ex(0, 1, 0, 0, 1, 0, 0, 0));
        add(0, 1, 0, ex(0, 1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) add(0, 0, 1, ex(0, 1, 0, 0, 1, 0, 0, 0));
        add(0, 0, 1, ex(0, 1, 1, 1, 1, 0, 0, 0));
        add(1, 0, 0, ex(1, 0, 1, 1, 1, 0, 0, 0));
        add(0, 0, 0, ex(0, 0, 1, 1, 1, 0, 0, 0));
        add(0, 1, 0, ex(0, 0, 1, 1, 1, 0, 0, 0));
        add(1, 0, 0, ex(1, 0, 1, 1, 1, 1, 0, 0));
        add(0, 0, 0, ex(0, 0, 1, 1, 1, 1, 0, 0));
        add(0, 1, 0, ex(0, 0, 1, 1, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) add(0, 0, 1, ex(0, 0, 1, 1, 1, 1, 0, 0));
        add(0, 0, 1, ex(0, 0, 0, 2, 1, 1, 0, 0));

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_held", ex(0, 1, 0, 0, 0, 0, 0, 0));
        rst_ni = 1'b1;
        step(0, 0, 0);
        check("reset_released", ex(0, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(int'(vecs[i].req), int'(vecs[i].done), int'(vecs[i].vid));
            check($sformatf("vec%0d", i), vecs[i].e);
        end

        // Done coinciding with frame end: repeat now, swap at the next frame end
        step(1, 0, 0);
        check("d_grant_bank1", ex(1, 1, 0, 2, 1, 1, 0, 0));
        step(0, 0, 0);
        beats(3);
        step(0, 1, 1);
        check("d_done_at_frame_end", ex(0, 1, 0, 2, 2, 1, 0, 0));
        beats(3);
        check("d_mid_frame", ex(0, 1, 0, 2, 2, 1, 0, 0));
        beats(1);
        check("d_late_swap", ex(0, 1, 1, 3, 2, 1, 0, 0));

        // Stalled tlast beats do not advance the row counter
        for (int i = 0; i < 5; i++) step(0, 0, 2);
        check("e_stall", ex(0, 1, 1, 3, 2, 1, 0, 0));
        beats(3);
        check("e_three_rows", ex(0, 1, 1, 3, 2, 1, 0, 0));
        beats(1);
        check("e_frame_end", ex(0, 1, 1, 3, 3, 1, 0, 0));

        // tuser at row 2 resyncs to row 0
        beats(2);
        step(0, 0, 3);
        check("e_tuser_resync", ex(0, 1, 1, 3, 3, 1, 1, 0));
        beats(3);
        check("e_after_resync", ex(0, 1, 1, 3, 3, 1, 1, 0));
        beats(1);
        check("e_resync_frame_end", ex(0, 1, 1, 3, 4, 1, 1, 0));

        // Repeat counter reaches and holds all-ones
        beats(12);
        check("sat_reach", ex(0, 1, 1, 3, 7, 1, 1, 0));
        beats(4);
        check("sat_hold", ex(0, 1, 1, 3, 7, 1, 1, 0));

        // Reset during W_WRITE abandons everything; a late done is a protocol error
        step(1, 0, 0);
        check("f_grant_bank0", ex(1, 0, 1, 3, 7, 1, 1, 0));
        step(0, 0, 1);
        rst_ni = 1'b0;
        step(0, 0, 0);
        check("f_reset_mid_write", ex(0, 1, 0, 0, 0, 0, 0, 0));
        rst_ni = 1'b1;
        step(0, 0, 0);
        check("f_after_reset", ex(0, 1, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0);
        check("f_stray_done", ex(0, 1, 0, 0, 0, 0, 0, 1));
        beats(4);
        check("f_no_swap_after_stray_done", ex(0, 1, 0, 0, 1, 0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
